// File: rtl/exmem_pipe.sv
// rtl/exmem_pipe.sv - EX/MEM pipeline register with a two-entry skid buffer
// The outputs always present the main entry. The skid entry only absorbs the one cycle of in_ready latency.
module exmem_pipe #(
    parameter int CTRL_W = 22,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] control_signals,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_W-1:0]  dest_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] control_signals_out,
    output logic [DATA_W-1:0] result_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic [REG_W-1:0]  dest_out,
    output logic [1:0]        mem_size,
    output logic              mem_se,
    output logic              mem_rw,
    output logic              mem_enable,
    output logic              load_instr,
    output logic              rf_enable,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state, state_nxt;

    logic              in_fire, out_fire;
    logic              load_main_in, load_main_skid, load_skid;

    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_res, skid_res;
    logic [DATA_W-1:0] main_sd, skid_sd;
    logic [REG_W-1:0]  main_dest, skid_dest;

    // in_ready depends only on the state register, so out_ready has no combinational path to it.
    assign in_ready  = (state != TWO);
    assign out_valid = (state == ONE) || (state == TWO);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // A flush kills both held entries and any entry arriving in the same cycle.
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_ctrl <= '0;
            main_res  <= '0;
            main_sd   <= '0;
            main_dest <= '0;
            skid_ctrl <= '0;
            skid_res  <= '0;
            skid_sd   <= '0;
            skid_dest <= '0;
        end else begin
            if (load_main_in) begin
                main_ctrl <= control_signals;
                main_res  <= alu_result;
                main_sd   <= store_data;
                main_dest <= dest_reg;
            end else if (load_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_res  <= skid_res;
                main_sd   <= skid_sd;
                main_dest <= skid_dest;
            end
            if (load_skid) begin
                skid_ctrl <= control_signals;
                skid_res  <= alu_result;
                skid_sd   <= store_data;
                skid_dest <= dest_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && !(&stall_count)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign control_signals_out = main_ctrl;
    assign result_out          = main_res;
    assign store_data_out      = main_sd;
    assign dest_out            = main_dest;

    // Side-effecting strobes are gated so that a bubble can never touch memory or the register file.
    assign mem_size   = out_valid ? main_ctrl[6:5] : 2'b00;
    assign mem_se     = out_valid & main_ctrl[3];
    assign mem_rw     = out_valid & main_ctrl[4];
    assign mem_enable = out_valid & main_ctrl[0];
    assign load_instr = out_valid & main_ctrl[10];
    assign rf_enable  = out_valid & main_ctrl[9];

endmodule

// File: tb/tb_exmem_pipe.sv
// tb/tb_exmem_pipe.sv - self-checking bench for exmem_pipe against a queue reference model
module tb_exmem_pipe;

    localparam int CTRL_W = 22;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 2;
    localparam int SMAX   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] res;
        logic [DATA_W-1:0] sd;
        logic [REG_W-1:0]  dest;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, out_ready;
    logic              in_ready, out_valid;
    logic [CTRL_W-1:0] control_signals, control_signals_out;
    logic [DATA_W-1:0] alu_result, store_data, result_out, store_data_out;
    logic [REG_W-1:0]  dest_reg, dest_out;
    logic [1:0]        mem_size;
    logic              mem_se, mem_rw, mem_enable, load_instr, rf_enable;
    logic [CNT_W-1:0]  stall_count;

    ent_t mq[$];
    int   mstall;
    int   n_vec = 0;
    int   n_err = 0;

    exmem_pipe #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .control_signals(control_signals), .alu_result(alu_result),
        .store_data(store_data), .dest_reg(dest_reg),
        .out_valid(out_valid), .out_ready(out_ready),
        .control_signals_out(control_signals_out), .result_out(result_out),
        .store_data_out(store_data_out), .dest_out(dest_out),
        .mem_size(mem_size), .mem_se(mem_se), .mem_rw(mem_rw),
        .mem_enable(mem_enable), .load_instr(load_instr), .rf_enable(rf_enable),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        ent_t h;
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("stall_count", 64'(stall_count), 64'(mstall));
        if (mq.size() > 0) begin
            h = mq[0];
            chk("ctrl_out", 64'(control_signals_out), 64'(h.ctrl));
            chk("result_out", 64'(result_out), 64'(h.res));
            chk("store_data_out", 64'(store_data_out), 64'(h.sd));
            chk("dest_out", 64'(dest_out), 64'(h.dest));
            chk("mem_size", 64'(mem_size), 64'(h.ctrl[6:5]));
            chk("mem_se", 64'(mem_se), 64'(h.ctrl[3]));
            chk("mem_rw", 64'(mem_rw), 64'(h.ctrl[4]));
            chk("mem_enable", 64'(mem_enable), 64'(h.ctrl[0]));
            chk("load_instr", 64'(load_instr), 64'(h.ctrl[10]));
            chk("rf_enable", 64'(rf_enable), 64'(h.ctrl[9]));
        end else begin
            chk("bubble_strobes", 64'({mem_size, mem_se, mem_rw, mem_enable, load_instr, rf_enable}), 64'd0);
        end
    endtask

    // Advance one clock, update the model from the inputs held across the edge, then compare.
    task automatic tick();
        int   sz;
        bit   mif, mof;
        ent_t e;
        sz  = mq.size();
        mif = in_valid && (sz < 2);
        mof = (sz > 0) && out_ready;
        e   = '{control_signals, alu_result, store_data, dest_reg};
        @(posedge clk);
        #1;
        if (reset) begin
            mq.delete();
            mstall = 0;
        end else begin
            if (sz > 0 && !out_ready && mstall < SMAX) mstall++;
            if (flush) begin
                mq.delete();
            end else begin
                if (mof) void'(mq.pop_front());
                if (mif) mq.push_back(e);
            end
        end
        check_all();
    endtask

    task automatic drive(input bit v);
        in_valid        = v;
        control_signals = CTRL_W'($urandom);
        alu_result      = $urandom;
        store_data      = $urandom;
        dest_reg        = REG_W'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] a_res, b_res, c_res, n_res;
        logic [CNT_W-1:0]  s_before;
        int                exp_stall[5];

        exp_stall = '{1, 2, 3, 3, 3};
        mstall    = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0);
        #1;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_payload", 64'(result_out | store_data_out), 64'd0);
        chk("reset_ctrl", 64'(control_signals_out), 64'd0);

        // Single load entry becomes visible one cycle after acceptance.
        drive(1'b1);
        control_signals = 22'h000601;
        out_ready = 1'b1;
        tick();
        drive(1'b0);
        chk("d035_mem_enable", 64'(mem_enable), 64'd1);
        chk("d035_rf_enable", 64'(rf_enable), 64'd1);
        chk("d035_load_instr", 64'(load_instr), 64'd1);
        chk("d035_mem_size", 64'(mem_size), 64'd0);
        tick();

        // Fill both slots under backpressure, then drain in order.
        do_reset();
        out_ready = 1'b0;
        drive(1'b1); a_res = alu_result; tick();
        drive(1'b1); b_res = alu_result; tick();
        chk("d036_in_ready", 64'(in_ready), 64'd0);
        chk("d036_head_a", 64'(result_out), 64'(a_res));
        drive(1'b1); c_res = alu_result; tick();
        chk("d036_still_a", 64'(result_out), 64'(a_res));
        out_ready = 1'b1;
        tick();
        chk("d036_head_b", 64'(result_out), 64'(b_res));
        tick();
        chk("d036_head_c", 64'(result_out), 64'(c_res));
        drive(1'b0);
        tick();
        chk("d036_drained", 64'(out_valid), 64'd0);

        // Simultaneous accept and deliver in ONE.
        drive(1'b1); tick();
        s_before = stall_count;
        drive(1'b1); n_res = alu_result; tick();
        chk("d037_head_new", 64'(result_out), 64'(n_res));
        chk("d037_in_ready", 64'(in_ready), 64'd1);
        chk("d037_stall_same", 64'(stall_count), 64'(s_before));
        drive(1'b0); tick();

        // Flush from TWO with a same-cycle input.
        out_ready = 1'b0;
        drive(1'b1); tick();
        drive(1'b1); tick();
        flush = 1'b1;
        drive(1'b1); tick();
        flush = 1'b0;
        chk("d038_out_valid", 64'(out_valid), 64'd0);
        chk("d038_in_ready", 64'(in_ready), 64'd1);
        chk("d038_mem_enable", 64'(mem_enable), 64'd0);
        drive(1'b0);
        out_ready = 1'b1;
        repeat (3) tick();

        // Stall counter saturation.
        do_reset();
        out_ready = 1'b0;
        drive(1'b1); tick();
        drive(1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("d039_stall_%0d", i), 64'(stall_count), 64'(exp_stall[i]));
        end

        // Reset takes priority over flush while full.
        drive(1'b1); tick();
        flush = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        chk("d040_out_valid", 64'(out_valid), 64'd0);
        chk("d040_stall", 64'(stall_count), 64'd0);
        chk("d040_result", 64'(result_out), 64'd0);
        chk("d040_ctrl", 64'(control_signals_out), 64'd0);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 4) != 0);
            out_ready = (($urandom % 3) != 0);
            flush     = (($urandom % 25) == 0);
            reset     = (($urandom % 150) == 0);
            tick();
        end
        reset = 1'b0;
        flush = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
